f1_start_ctrl: RTL and testbench
================================

Name: f1_start_ctrl

Overview:
Sequencer for the 9-state F1 start-light FSM (S0 all off, S1..S8 = 1..8 lights on), driving its `en` input.
- Paces the eight light-on steps at a fixed tick interval after a trigger.
- Holds all lights on for a pseudo-random delay, then pulses the FSM back to S0 (lights out).
- Measures driver reaction time in ticks until `stop` is asserted.
- Shares `clk`/`rst` with the light FSM so both reset together.

Parameters:
- TICK_DIV, 1000: clk cycles per tick; minimum 2.
- DELAY_W, 7: width of the random delay field; delay range is 1..2^DELAY_W-1 ticks.
- TIME_W, 16: width of the reaction-time counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- trigger  in  1  start request, level-sampled
- stop  in  1  driver reaction input, level-sampled
- step_en  out  1  one-cycle pulse to light FSM `en`
- cmd_seq  out  1  high while stepping lights (SEQ state)
- cmd_delay  out  1  high during random hold (DELAY state)
- lights_off  out  1  one-cycle pulse, coincident with the 9th step_en
- busy  out  1  high in any state except IDLE
- reaction_time  out  TIME_W  last measured reaction, in ticks
- time_valid  out  1  one-cycle pulse when reaction_time updates

Behaviour:
- Reset values: state IDLE; all 1-bit outputs 0; reaction_time 0; tick, step and delay counters 0; LFSR 16'h0001.
- LFSR:
  - 16-bit Fibonacci, feedback = q[15]^q[13]^q[12]^q[10], shifted into bit 0.
  - Advances every clk cycle, including IDLE; never all-zero.
- Tick counter:
  - Counts 0..TICK_DIV-1; cleared on every state entry.
  - "tick" = cycle where the count equals TICK_DIV-1.
  - Runs only in SEQ, DELAY and TIMING.
- IDLE:
  - trigger=1 -> SEQ next cycle; step counter cleared.
  - stop is ignored.
- SEQ (cmd_seq=1):
  - Each tick: step_en=1 for that cycle, step counter +1.
  - The first step_en occurs TICK_DIV cycles after SEQ entry.
  - On the tick giving the 8th pulse: -> DELAY, and delay_cnt loads LFSR[DELAY_W-1:0] (value 0 is substituted by 1).
- DELAY (cmd_delay=1):
  - Each tick, delay_cnt decrements.
  - On the tick where delay_cnt==1: step_en=1 and lights_off=1 (same cycle) -> TIMING, reaction counter cleared.
- TIMING:
  - Reaction counter +1 per tick, saturating at 2^TIME_W-1.
  - stop=1: reaction_time <= counter, time_valid=1 for that cycle -> IDLE.
  - stop already high at TIMING entry -> captured value 0.
- step_en count: exactly 9 pulses per completed run, returning the light FSM to S0.
- trigger while busy: ignored. trigger held high across the return to IDLE starts a new run on the next cycle.
- stop and a tick in the same cycle (TIMING): capture the pre-increment value.
- rst mid-run:
  - Immediate return to IDLE; all outputs revert to reset values.
  - The light FSM resets to S0 in the same cycle, so no resynchronisation is needed.
- reaction_time holds its value until the next capture or rst.

Optional Feature:
F1_JUMP_START_EN
- With the macro: adds output port `jump_start` (1 bit).
  - stop=1 during SEQ or DELAY -> jump_start=1 for one cycle, reaction_time <= {TIME_W{1'b1}}, time_valid=1, state -> IDLE.
  - No further step_en pulses are issued; the light FSM is left at its current state until rst.
- Without the macro: no `jump_start` port; stop is ignored outside TIMING.

Decomposition:
- Package f1_pkg holds:
  - state enum {IDLE, SEQ, DELAY, TIMING};
  - NUM_LIGHTS=8;
  - LFSR_SEED=16'h0001;
  - LFSR tap constants.
- One natural sub-module: f1_lfsr16 (clk, rst, q[15:0]), free-running.
- Tick, step, delay and reaction counters plus the FSM stay in f1_start_ctrl.

Test Plan:
- TICK_DIV=4, trigger pulse in IDLE -> cmd_seq=1 next cycle; step_en pulses at 4, 8, ..., 32 cycles after SEQ entry; cmd_delay=1 the cycle after the 8th pulse.
- DELAY_W=3, LFSR forced so loaded value is 0 -> substituted delay 1; lights_off with 9th step_en exactly 4 cycles after DELAY entry.
- Full run, stop asserted 10 ticks after lights_off -> reaction_time=10, time_valid single-cycle, busy=0, light FSM at S0 (data_out=0).
- rst asserted mid-DELAY -> next cycle all outputs 0, state IDLE; a new trigger restarts with the first step_en after TICK_DIV cycles.
- TIME_W=4, no stop for 20 ticks -> counter saturates at 15; stop -> reaction_time=15.
- With F1_JUMP_START_EN: stop during SEQ after the 3rd step_en -> jump_start=1, reaction_time=all ones, no further step_en pulses. Without the macro, the same stimulus completes the normal run.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEQ    = 2'd1,
    DELAY  = 2'd2,
    TIMING = 2'd3
  } f1_state_e;

  localparam int          NUM_LIGHTS = 8;
  localparam int          STEP_W     = $clog2(NUM_LIGHTS);
  localparam logic [15:0] LFSR_SEED  = 16'h0001;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/f1_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the random hold-delay source.
module f1_lfsr16
  import f1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: paces eight light steps, random hold, lights-out, reaction timing.
// Optional jump-start detection is enabled by defining F1_JUMP_START_EN.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DELAY_W  = 7,
  parameter int TIME_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              stop,
  output logic              step_en,
  output logic              cmd_seq,
  output logic              cmd_delay,
  output logic              lights_off,
  output logic              busy,
  output logic [TIME_W-1:0] reaction_time,
  output logic              time_valid
`ifdef F1_JUMP_START_EN
  ,
  output logic              jump_start
`endif
);

  localparam int                 TCNT_W    = $clog2(TICK_DIV);
  localparam logic [TCNT_W-1:0]  TICK_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0]  TICK_ONE  = TCNT_W'(1);
  localparam logic [TCNT_W-1:0]  TICK_ZERO = {TCNT_W{1'b0}};
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(NUM_LIGHTS - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
  localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
  localparam logic [TIME_W-1:0]  TIME_MAX  = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0]  TIME_ONE  = TIME_W'(1);

  f1_state_e          state_q, state_d;
  logic [TCNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [TIME_W-1:0]  react_cnt_q, react_cnt_d;
  logic [TIME_W-1:0]  reaction_time_q, reaction_time_d;
  logic               step_en_q, step_en_d;
  logic               cmd_seq_q, cmd_seq_d;
  logic               cmd_delay_q, cmd_delay_d;
  logic               lights_off_q, lights_off_d;
  logic               busy_q, busy_d;
  logic               time_valid_q, time_valid_d;
  logic               jump_start_d;

  logic [15:0]        lfsr_s;
  logic [DELAY_W-1:0] delay_seed_s;
  logic               tick_s;
  logic               tick_next_s;
  logic               jump_s;
  logic               unused_lfsr_s;

  f1_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_s)
  );

  assign delay_seed_s  = (lfsr_s[DELAY_W-1:0] == {DELAY_W{1'b0}}) ? DELAY_ONE
                                                                  : lfsr_s[DELAY_W-1:0];
  assign unused_lfsr_s = ^lfsr_s[15:DELAY_W];
  assign tick_s        = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);

`ifdef F1_JUMP_START_EN
  assign jump_s = stop;
`else
  assign jump_s = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    step_cnt_d      = step_cnt_q;
    delay_cnt_d     = delay_cnt_q;
    react_cnt_d     = react_cnt_q;
    reaction_time_d = reaction_time_q;
    time_valid_d    = 1'b0;
    jump_start_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = SEQ;
          step_cnt_d = {STEP_W{1'b0}};
        end else begin
          state_d    = IDLE;
        end
      end
      SEQ: begin
        if (jump_s) begin
          state_d         = IDLE;
          reaction_time_d = TIME_MAX;
          time_valid_d    = 1'b1;
          jump_start_d    = 1'b1;
        end else if (tick_s) begin
          step_cnt_d = step_cnt_q + STEP_ONE;
          if (step_cnt_q == STEP_LAST) begin
            state_d     = DELAY;
            delay_cnt_d = delay_seed_s;
          end else begin
            state_d     = SEQ;
          end
        end else begin
          state_d = SEQ;
        end
      end
      DELAY: begin
        if (jump_s) begin
          state_d         = IDLE;
          reaction_time_d = TIME_MAX;
          time_valid_d    = 1'b1;
          jump_start_d    = 1'b1;
        end else if (tick_s) begin
          delay_cnt_d = delay_cnt_q - DELAY_ONE;
          if (delay_cnt_q == DELAY_ONE) begin
            state_d     = TIMING;
            react_cnt_d = {TIME_W{1'b0}};
          end else begin
            state_d     = DELAY;
          end
        end else begin
          state_d = DELAY;
        end
      end
      TIMING: begin
        // A stop coinciding with a tick captures the count before that tick.
        if (stop) begin
          state_d         = IDLE;
          reaction_time_d = react_cnt_q;
          time_valid_d    = 1'b1;
        end else if (tick_s && (react_cnt_q != TIME_MAX)) begin
          react_cnt_d = react_cnt_q + TIME_ONE;
        end else begin
          react_cnt_d = react_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    tick_cnt_d = TICK_ZERO;
    if ((state_d != state_q) || (state_q == IDLE)) begin
      tick_cnt_d = TICK_ZERO;
    end else if (tick_s) begin
      tick_cnt_d = TICK_ZERO;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end
    tick_next_s  = (state_d != IDLE) && (tick_cnt_d == TICK_LAST);
    lights_off_d = tick_next_s && (state_d == DELAY) && (delay_cnt_d == DELAY_ONE);
    step_en_d    = (tick_next_s && (state_d == SEQ)) || lights_off_d;
    cmd_seq_d    = (state_d == SEQ);
    cmd_delay_d  = (state_d == DELAY);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      tick_cnt_q      <= TICK_ZERO;
      step_cnt_q      <= {STEP_W{1'b0}};
      delay_cnt_q     <= {DELAY_W{1'b0}};
      react_cnt_q     <= {TIME_W{1'b0}};
      reaction_time_q <= {TIME_W{1'b0}};
      step_en_q       <= 1'b0;
      cmd_seq_q       <= 1'b0;
      cmd_delay_q     <= 1'b0;
      lights_off_q    <= 1'b0;
      busy_q          <= 1'b0;
      time_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      step_cnt_q      <= step_cnt_d;
      delay_cnt_q     <= delay_cnt_d;
      react_cnt_q     <= react_cnt_d;
      reaction_time_q <= reaction_time_d;
      step_en_q       <= step_en_d;
      cmd_seq_q       <= cmd_seq_d;
      cmd_delay_q     <= cmd_delay_d;
      lights_off_q    <= lights_off_d;
      busy_q          <= busy_d;
      time_valid_q    <= time_valid_d;
    end
  end

  assign step_en       = step_en_q;
  assign cmd_seq       = cmd_seq_q;
  assign cmd_delay     = cmd_delay_q;
  assign lights_off    = lights_off_q;
  assign busy          = busy_q;
  assign reaction_time = reaction_time_q;
  assign time_valid    = time_valid_q;

`ifdef F1_JUMP_START_EN
  logic jump_start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      jump_start_q <= 1'b0;
    end else begin
      jump_start_q <= jump_start_d;
    end
  end

  assign jump_start = jump_start_q;
`else
  logic unused_jump_s;
  assign unused_jump_s = jump_start_d;
`endif

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Self-checking bench for f1_start_ctrl against a cycle-schedule reference model.
module tb_f1_start_ctrl;

  localparam int TD = 4;
  localparam int DW = 3;
  localparam int TW = 4;
  localparam logic [TW-1:0] RT_MAX = {TW{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trigger = 1'b0;
  logic          stop = 1'b0;
  logic          step_en, cmd_seq, cmd_delay, lights_off, busy, time_valid;
  logic [TW-1:0] reaction_time;
`ifdef F1_JUMP_START_EN
  logic          jump_start;
`endif

  int            n_checks = 0;
  int            n_fail = 0;
  logic [15:0]   m_lfsr;
  logic [TW-1:0] exp_rt = {TW{1'b0}};
  int            lamp = 0;

  f1_start_ctrl #(.TICK_DIV(TD), .DELAY_W(DW), .TIME_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger       (trigger),
    .stop          (stop),
    .step_en       (step_en),
    .cmd_seq       (cmd_seq),
    .cmd_delay     (cmd_delay),
    .lights_off    (lights_off),
    .busy          (busy),
    .reaction_time (reaction_time),
    .time_valid    (time_valid)
`ifdef F1_JUMP_START_EN
    ,
    .jump_start    (jump_start)
`endif
  );

  always #5 clk = ~clk;

  // Reference LFSR: the spec's shift rule, advanced on every clock.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'h0001;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [15:0] lfsr_ahead(input logic [15:0] v, input int n);
    logic [15:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    return x;
  endfunction

  // One complete run starting with trigger in the current cycle (t=0).
  // Stop is raised r cycles after the lights-off cycle.
  task automatic run_once(input string tag, input int r, input bit hold);
    int p, s, d, pulses, rt_int;
    bit done;
    logic [5:0] obs, expv;
    bit e_seq, e_dly, e_step, e_loff;
    p = 1 << 30; s = 1 << 30; d = 0; pulses = 0; done = 1'b0;
    trigger = 1'b1;
    stop = 1'b0;
    for (int t = 1; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (t == 8 * TD) begin
        d = int'(m_lfsr[DW-1:0]);
        if (d == 0) d = 1;
        p = 8 * TD + d * TD;
        s = p + r;
      end
      e_seq  = (t <= 8 * TD);
      e_dly  = (t > 8 * TD) && (t <= p);
      e_loff = (t == p);
      e_step = (e_seq && (t % TD == 0)) || e_loff;
      obs  = {step_en, lights_off, cmd_seq, cmd_delay, busy, time_valid};
      expv = {e_step, e_loff, e_seq, e_dly, (t <= s), (t == s + 1)};
      if (step_en === 1'b1) begin
        pulses++;
        lamp = (lamp + 1) % 9;
      end
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s t=%0d {step,loff,seq,dly,busy,tv} got=%b want=%b", tag, t, obs, expv);
      end
`ifdef F1_JUMP_START_EN
      n_checks++;
      if (jump_start !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_jump t=%0d got=%b want=0", tag, t, jump_start);
      end
`endif
      if (t == s + 1) begin
        rt_int = (r - 1) / TD;
        exp_rt = (rt_int > int'(RT_MAX)) ? RT_MAX : TW'(rt_int);
        done = 1'b1;
        n_checks++;
        if (pulses != 9) begin
          n_fail++;
          $display("FAIL %s_pulses got=%0d want=9", tag, pulses);
        end
        n_checks++;
        if (lamp != 0) begin
          n_fail++;
          $display("FAIL %s_light_state got=%0d want=0", tag, lamp);
        end
      end
      n_checks++;
      if (reaction_time !== exp_rt) begin
        n_fail++;
        $display("FAIL %s_rt t=%0d got=%0d want=%0d", tag, t, reaction_time, exp_rt);
      end
      if (done) begin
        trigger = hold;
        stop = 1'b0;
      end else begin
        trigger = 1'($urandom_range(0, 1));
        if (t == s) stop = 1'b1;
        else if (t > p) stop = 1'b0;
        else begin
`ifdef F1_JUMP_START_EN
          stop = 1'b0;
`else
          stop = ($urandom_range(0, 7) == 0) || (t == 3 * TD + 1);
`endif
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout got=unfinished want=finished", tag);
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1; trigger = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    obs = {step_en, cmd_seq, cmd_delay, lights_off, busy, time_valid, reaction_time};
    n_checks++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset got=%b want=%b", obs, 10'd0);
    end
    rst = 1'b0; trigger = 1'b0; stop = 1'b0;
    lamp = 0; exp_rt = {TW{1'b0}};
  endtask

  task automatic test_zero_delay();
    bit found;
    logic [15:0] ahead;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      ahead = lfsr_ahead(m_lfsr, 8 * TD);
      if (ahead[DW-1:0] == 3'd0) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL zero_delay_search got=none want=found");
    end else begin
      run_once("zero_delay", 1 + TD * $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    logic [9:0] obs;
    found = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      trigger = 1'b0;
      if (cmd_delay === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_reset_wait got=no_delay want=delay");
    end
    rst = 1'b1;
    @(negedge clk);
    obs = {step_en, cmd_seq, cmd_delay, lights_off, busy, time_valid, reaction_time};
    n_checks++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b want=%b", obs, 10'd0);
    end
    rst = 1'b0;
    lamp = 0; exp_rt = {TW{1'b0}};
    run_once("restart", 1 + $urandom_range(0, 30), 1'b0);
  endtask

`ifdef F1_JUMP_START_EN
  task automatic test_jump_start();
    logic [6:0] obs, expv;
    bit e_step, e_js, e_busy;
    trigger = 1'b1; stop = 1'b0;
    for (int t = 1; t <= 3 * TD + 40; t++) begin
      @(negedge clk);
      trigger = 1'b0;
      e_step = (t <= 3 * TD) && (t % TD == 0);
      e_js   = (t == 3 * TD + 2);
      e_busy = (t <= 3 * TD + 1);
      obs  = {step_en, cmd_seq, busy, jump_start, time_valid, lights_off, cmd_delay};
      expv = {e_step, e_busy, e_busy, e_js, e_js, 1'b0, 1'b0};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL jump t=%0d {step,seq,busy,js,tv,loff,dly} got=%b want=%b", t, obs, expv);
      end
      if (e_js) begin
        n_checks++;
        if (reaction_time !== RT_MAX) begin
          n_fail++;
          $display("FAIL jump_rt got=%0d want=%0d", reaction_time, RT_MAX);
        end
      end
      stop = (t == 3 * TD + 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lamp = 0; exp_rt = {TW{1'b0}};
  endtask
`endif

  initial begin
    test_reset();
    run_once("basic", 1 + $urandom_range(0, 12), 1'b0);
    run_once("react10", 10 * TD + 1 + $urandom_range(0, TD - 1), 1'b0);
    run_once("stop_at_entry", 1, 1'b0);
    run_once("back_to_back_a", 1 + $urandom_range(0, 20), 1'b1);
    run_once("back_to_back_b", 1 + $urandom_range(0, 20), 1'b0);
    run_once("saturate", 20 * TD + 1, 1'b0);
    test_zero_delay();
    test_reset_mid_run();
    for (int k = 0; k < 4; k++) begin
      run_once("random", 1 + $urandom_range(0, 90), 1'($urandom_range(0, 1)));
    end
    trigger = 1'b0;
    @(negedge clk);
`ifdef F1_JUMP_START_EN
    test_jump_start();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
